// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a big-endian 32-bit word stream into 512-bit blocks
// and appends the 0x80 marker, zero fill and 64-bit bit length.
module sha256_msg_padder #(
    parameter int LEN_WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] PAD  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]           state;
    logic [31:0]          buf_q [16];
    logic [3:0]           widx;
    logic [LEN_WIDTH-1:0] len;
    logic                 pad_pending;
    logic                 first_q;
    logic                 cont_q;
    logic                 last_q;

    logic                 in_fire;
    logic                 blk_fire;
    logic [2:0]           nbytes_eff;
    logic [31:0]          last_word;
    logic [LEN_WIDTH-1:0] len_inc;
    logic [63:0]          len64;

    assign in_ready  = (state == FILL) & ~rst;
    assign blk_valid = (state == OUT) & ~rst;
    assign blk_first = first_q;
    assign blk_last  = last_q;

    assign in_fire  = in_valid & in_ready;
    assign blk_fire = blk_valid & blk_ready;

    // Out-of-range byte counts behave as a full word.
    assign nbytes_eff = ((in_nbytes == 3'd0) || (in_nbytes > 3'd4)) ? 3'd4 : in_nbytes;
    assign len_inc    = in_last ? LEN_WIDTH'({nbytes_eff, 3'b000}) : LEN_WIDTH'(32);
    assign len64      = 64'(len);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        last_word = in_data;
        case (nbytes_eff)
            3'd1:    last_word = {in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {in_data[31:16], 16'h8000};
            3'd3:    last_word = {in_data[31:8],  8'h80};
            default: last_word = in_data;
        endcase
    end

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 16; i++) begin
            blk_data[511 - 32*i -: 32] = buf_q[i];
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch
    // reads the pre-edge values of widx, len and the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            widx        <= '0;
            len         <= '0;
            pad_pending <= 1'b0;
            first_q     <= 1'b1;
            cont_q      <= 1'b0;
            last_q      <= 1'b0;
            // NOTE: the buffer is cleared on reset because blk_data exposes it directly.
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        buf_q[widx] <= in_last ? last_word : in_data;
                        len         <= len + len_inc;
                        widx        <= widx + 4'd1;
                        if (in_last) begin
                            pad_pending <= (nbytes_eff == 3'd4);
                            if (widx == 4'd15) begin
                                // Marker or its pending write spills into a trailing block.
                                state  <= OUT;
                                last_q <= 1'b0;
                                cont_q <= 1'b1;
                            end else begin
                                state <= PAD;
                            end
                        end else if (widx == 4'd15) begin
                            state  <= OUT;
                            last_q <= 1'b0;
                            cont_q <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    if (pad_pending) begin
                        buf_q[widx] <= 32'h8000_0000;
                        pad_pending <= 1'b0;
                        widx        <= widx + 4'd1;
                        if (widx == 4'd15) begin
                            state  <= OUT;
                            last_q <= 1'b0;
                            cont_q <= 1'b1;
                        end
                    end else if (widx == 4'd14) begin
                        buf_q[14] <= len64[63:32];
                        buf_q[15] <= len64[31:0];
                        widx      <= '0;
                        state     <= OUT;
                        last_q    <= 1'b1;
                        cont_q    <= 1'b0;
                    end else begin
                        buf_q[widx] <= '0;
                        widx        <= widx + 4'd1;
                        if (widx == 4'd15) begin
                            state  <= OUT;
                            last_q <= 1'b0;
                            cont_q <= 1'b1;
                        end
                    end
                end

                OUT: begin
                    if (blk_fire) begin
                        first_q <= 1'b0;
                        widx    <= '0;
                        if (cont_q) begin
                            state  <= PAD;
                            cont_q <= 1'b0;
                        end else if (last_q) begin
                            state   <= FILL;
                            len     <= '0;
                            first_q <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks for short,
// boundary-length and back-pressured messages, plus reset mid-fill.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    int checks = 0;
    int errors = 0;
    logic [31:0] ew [16];
    logic [511:0] held;

    sha256_msg_padder #(.LEN_WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] d(input int i);
        return 32'(32'h1111_1111 * (i + 1));
    endfunction

    function automatic logic [511:0] pack_ew();
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = ew[i];
        return b;
    endfunction

    task automatic clear_ew();
        for (int i = 0; i < 16; i++) ew[i] = '0;
    endtask

    // Called and returns on a falling edge; one word per cycle when in_ready stays high.
    task automatic send(input logic [31:0] data, input logic last, input logic [2:0] nb);
        int n = 0;
        in_data   = data;
        in_valid  = 1'b1;
        in_last   = last;
        in_nbytes = nb;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 512'(in_ready), 512'(1'b1));
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!blk_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 512'(blk_valid), 512'(1'b1));
    endtask

    task automatic recv_block(input string tag, input logic exp_first, input logic exp_last);
        wait_valid(tag);
        if (blk_valid) begin
            check({tag, "_data"},  blk_data, pack_ew());
            check({tag, "_first"}, 512'(blk_first), 512'(exp_first));
            check({tag, "_last"},  512'(blk_last),  512'(exp_last));
            blk_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            blk_ready = 1'b0;
        end
    endtask

    task automatic abc_msg(input string tag);
        send(32'h6162_6300, 1'b1, 3'd3);
        clear_ew();
        ew[0]  = 32'h6162_6380;
        ew[15] = 32'h0000_0018;
        recv_block(tag, 1'b1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = '0;
        blk_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  512'(in_ready),  512'(1'b0));
        check("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready",  512'(in_ready),  512'(1'b1));
        check("post_rst_blk_valid", 512'(blk_valid), 512'(1'b0));
        check("post_rst_first",     512'(blk_first), 512'(1'b1));
        check("post_rst_last",      512'(blk_last),  512'(1'b0));
        check("post_rst_data",      blk_data,        512'(0));
        @(negedge clk);

        abc_msg("abc");

        // 55 bytes: marker lands in the low byte of word 13, length fits.
        for (int i = 0; i < 13; i++) send(d(i), 1'b0, 3'd0);
        send(32'hAABB_CCDD, 1'b1, 3'd3);
        clear_ew();
        for (int i = 0; i < 13; i++) ew[i] = d(i);
        ew[13] = 32'hAABB_CC80;
        ew[15] = 32'h0000_01B8;
        recv_block("b55", 1'b1, 1'b1);

        // 56 bytes: marker lands in word 14, forcing a length-only block.
        for (int i = 0; i < 13; i++) send(d(i), 1'b0, 3'd0);
        send(d(13), 1'b1, 3'd4);
        clear_ew();
        for (int i = 0; i < 14; i++) ew[i] = d(i);
        ew[14] = 32'h8000_0000;
        recv_block("b56a", 1'b1, 1'b0);
        clear_ew();
        ew[15] = 32'h0000_01C0;
        recv_block("b56b", 1'b0, 1'b1);

        // 64 bytes: raw block, then marker-and-length block.
        for (int i = 0; i < 15; i++) send(d(i), 1'b0, 3'd0);
        send(d(15), 1'b1, 3'd4);
        for (int i = 0; i < 16; i++) ew[i] = d(i);
        recv_block("b64a", 1'b1, 1'b0);
        clear_ew();
        ew[0]  = 32'h8000_0000;
        ew[15] = 32'h0000_0200;
        recv_block("b64b", 1'b0, 1'b1);

        // Two bytes; trailing input bytes must be masked off.
        send(32'h6162_FFFF, 1'b1, 3'd2);
        clear_ew();
        ew[0]  = 32'h6162_8000;
        ew[15] = 32'h0000_0010;
        recv_block("ab", 1'b1, 1'b1);

        // in_nbytes=0 on the last beat behaves as 4.
        send(32'hDEAD_BEEF, 1'b1, 3'd0);
        clear_ew();
        ew[0]  = 32'hDEAD_BEEF;
        ew[1]  = 32'h8000_0000;
        ew[15] = 32'h0000_0020;
        recv_block("nb0", 1'b1, 1'b1);

        // Back-pressure: hold the block for 5 cycles, then accept.
        send(32'h0102_0304, 1'b0, 3'd0);
        send(32'h1234_5678, 1'b1, 3'd1);
        clear_ew();
        ew[0]  = 32'h0102_0304;
        ew[1]  = 32'h1280_0000;
        ew[15] = 32'h0000_0028;
        wait_valid("bp_wait");
        held = blk_data;
        check("bp_initial_data", held, pack_ew());
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_data",     blk_data,        held);
            check("bp_hold_valid",    512'(blk_valid), 512'(1'b1));
            check("bp_hold_in_ready", 512'(in_ready),  512'(1'b0));
            check("bp_hold_first",    512'(blk_first), 512'(1'b1));
            check("bp_hold_last",     512'(blk_last),  512'(1'b1));
        end
        recv_block("bp", 1'b1, 1'b1);
        abc_msg("abc_after_bp");

        // Reset after 7 words discards the partial message.
        for (int i = 0; i < 7; i++) send(d(i), 1'b0, 3'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 512'(in_ready), 512'(1'b0));
        @(negedge clk);
        check("mid_rst_blk_valid", 512'(blk_valid), 512'(1'b0));
        rst = 1'b0;
        #1;
        check("mid_rst_release_in_ready", 512'(in_ready), 512'(1'b1));
        abc_msg("abc_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 hash engine. Accepts a byte-aligned message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length.
- Emits 512-bit message blocks through a valid/ready handshake. `blk_first` drives the engine's hash clear; `blk_valid & blk_ready` drives its load.

Parameters:
- LEN_WIDTH, 64, width of the internal bit-length counter. Zero-extended to 64 bits in the length field. Legal range 16..64.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- in_data  in  32  message word; first byte in [31:24]
- in_valid  in  1  in_data valid
- in_last  in  1  final word of message
- in_nbytes  in  3  valid bytes on last beat, 1..4, left-justified; ignored unless in_last
- in_ready  out  1  word accepted when in_valid & in_ready
- blk_data  out  512  padded block; word 0 at [511:480], first byte at [511:504]
- blk_valid  out  1  block available
- blk_ready  in  1  consumer accepts block when blk_valid & blk_ready
- blk_first  out  1  block is the first of its message
- blk_last  out  1  block is the final (length-bearing) block of its message

Behaviour:
- **Storage and counters:** 16x32 word buffer, 4-bit write index `widx`, LEN_WIDTH bit counter `len`, flags `pad_pending` and `first_q`.
- **FSM states:** FILL, PAD, OUT.
- **Combinational outputs:** `in_ready = (state==FILL) & ~rst`. `blk_valid = (state==OUT)`. `blk_data` is the buffer contents.
- **Reset:** state=FILL, widx=0, len=0, pad_pending=0, first_q=1, blk_last=0, buffer=0. While rst=1: in_ready=0 and blk_valid=0.
- **Reset mid-operation:** discards any partial message or pending block. No output handshake completes in the reset cycle.
- **FILL, non-last beat accepted:**
  - buf[widx]=in_data; len+=32; widx++.
  - If widx was 15: go to OUT with blk_last=0. blk_valid rises the cycle after the 16th word.
- **FILL, last beat accepted:**
  - len += 8*in_nbytes.
  - nbytes<4: store the word with byte[nbytes]=0x80 and the remaining lower bytes zeroed. Input bytes below nbytes are masked to zero before insertion.
  - nbytes=4: store the word unchanged and set pad_pending.
  - widx++, then go to PAD. If widx was 15 on this beat, go to OUT with blk_last=0 instead.
- **PAD (one word per cycle, in_ready=0):**
  - If pad_pending: buf[widx]=0x80000000 and clear pad_pending.
  - Else if widx<14: buf[widx]=0.
  - Else if widx==14 and the 0x80 byte is already placed: write buf[14]=len[63:32] and buf[15]=len[31:0] in the same cycle, then go to OUT with blk_last=1.
  - Whenever widx wraps past 15 before the length is written: go to OUT with blk_last=0, and resume PAD at widx=0 after the handshake.
- **OUT:**
  - blk_data, blk_first and blk_last are held stable until blk_ready.
  - On handshake: buffer is not cleared (every word is rewritten before the next OUT); first_q clears.
  - If a padding continuation is pending: go to PAD, widx=0.
  - Else if blk_last: go to FILL with widx=0, len=0, first_q=1.
  - Else: go to FILL with widx=0.
- **Block flags:** blk_first=first_q. A single-block message has blk_first=blk_last=1.
- **Padding placement:**
  - If the data ends with the 0x80 byte landing in word ≤13, a single trailing block results.
  - If the 0x80 lands in word 14 or 15, an extra block is generated: zeros in words 0..13, then the length.
- **Zero-length messages:** unsupported; in_last requires in_nbytes≥1. in_nbytes=0 or >4 is treated as 4.
- **Length overflow:** length beyond 2^LEN_WIDTH-1 wraps silently.
- **Throughput:** one input word per cycle in FILL. Block-to-block bubble is 1 cycle minimum.

Test Plan:
- **"abc":** in_data=0x61626300, in_last=1, nbytes=3 -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018; blk_first=1, blk_last=1.
- **55 bytes:** 13 full words + nbytes=3 -> single block; w13 low byte=0x80, w14=0, w15=0x000001B8, blk_last=1.
- **56 bytes:** 14 words, last nbytes=4 -> block 1: w14=0x80000000, w15=0, first=1, last=0. Block 2: w0..w14=0, w15=0x000001C0, first=0, last=1.
- **64 bytes:** 16 words -> block 1 is the raw data (last=0). Block 2: w0=0x80000000, zeros, w15=0x00000200, last=1.
- **Backpressure:** hold blk_ready=0 for 5 cycles in OUT -> blk_data/flags stable, in_ready=0; accept on cycle 6; next message's blk_first=1.
- **Reset mid-fill:** assert rst after 7 words -> next cycle blk_valid=0, in_ready=1 once rst drops. A fresh "abc" then produces the exact block from the first scenario.
